// File: rtl/msk_demod_pkg.sv
// ---------------------------------------------------------------------------
// msk_demod_pkg
// Shared types and constants for the MSK demodulator bit-decision slice.
//   sync_type_t   : kind of the most recent accepted timing strobe
//   SYNC_HALF_PER : nominal clocks between an I and the following Q strobe
//   IVL_W         : width of the strobe interval counter (saturates at 63)
//   LOCK_CNT_DEF  : default number of consecutive good strobes for lock
//   TOL_DEF       : default accepted interval deviation in clocks
// ---------------------------------------------------------------------------
package msk_demod_pkg;

    typedef enum logic [1:0] {
        SYNC_NONE = 2'd0,
        SYNC_I    = 2'd1,
        SYNC_Q    = 2'd2
    } sync_type_t;

    localparam int SYNC_HALF_PER = 16;
    localparam int IVL_W         = 6;
    localparam int LOCK_CNT_DEF  = 8;
    localparam int TOL_DEF       = 2;

endpackage

// File: rtl/msk_sync_lock.sv
// ---------------------------------------------------------------------------
// msk_sync_lock
// Watches the I/Q decision strobes for spacing and alternation, and derives
// timing lock plus a one-clock protocol-error pulse.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   isync_i       : I decision strobe
//   qsync_i       : Q decision strobe
//   lock_o        : registered, high while good_cnt == LOCK_CNT
//   sync_err_o    : registered one-clock pulse on repeated-type or
//                   simultaneous strobes
// ---------------------------------------------------------------------------
module msk_sync_lock
    import msk_demod_pkg::*;
#(
    parameter int HALF_PER = SYNC_HALF_PER,
    parameter int TOL      = TOL_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic isync_i,
    input  logic qsync_i,
    output logic lock_o,
    output logic sync_err_o
);

    localparam int CNT_W  = $clog2(LOCK_CNT + 1);
    localparam int WIN_LO = HALF_PER - TOL;
    localparam int WIN_HI = HALF_PER + TOL;

    localparam logic [IVL_W-1:0] IVL_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CNT);

    logic [IVL_W-1:0] ivl_q, ivl_d;
    logic [CNT_W-1:0] good_q, good_d;
    sync_type_t       last_q, last_d;
    logic             lock_q, lock_d;
    logic             err_q, err_d;

    logic             accept;
    logic             clash;
    logic             in_win;
    sync_type_t       cur_type;

    function automatic logic [IVL_W-1:0] ivl_inc(input logic [IVL_W-1:0] v);
        return (v == IVL_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] good_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1'b1;
    endfunction

    always_comb begin
        accept   = isync_i ^ qsync_i;
        clash    = isync_i & qsync_i;
        cur_type = isync_i ? SYNC_I : SYNC_Q;
        // Saturated ivl (63) is always beyond WIN_HI, so long gaps fail here.
        in_win   = (int'(ivl_q) >= WIN_LO) && (int'(ivl_q) <= WIN_HI);

        ivl_d  = ivl_inc(ivl_q);
        last_d = last_q;
        good_d = good_q;
        err_d  = 1'b0;

        if (clash) begin
            // Illegal strobe pair: timing history is frozen, only lock is lost.
            ivl_d  = ivl_q;
            good_d = '0;
            err_d  = 1'b1;
        end else if (accept) begin
            ivl_d  = IVL_W'(1);
            last_d = cur_type;
            if (last_q == SYNC_NONE) begin
                good_d = good_q;
            end else if (last_q == cur_type) begin
                good_d = '0;
                err_d  = 1'b1;
            end else if (in_win) begin
                good_d = good_inc(good_q);
            end else begin
                good_d = '0;
            end
        end

        lock_d = (good_d == CNT_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ivl_q  <= '0;
            good_q <= '0;
            last_q <= SYNC_NONE;
            lock_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ivl_q  <= ivl_d;
            good_q <= good_d;
            last_q <= last_d;
            lock_q <= lock_d;
            err_q  <= err_d;
        end
    end

    assign lock_o     = lock_q;
    assign sync_err_o = err_q;

endmodule

// File: rtl/msk_bit_decision.sv
// ---------------------------------------------------------------------------
// msk_bit_decision
// MSK demodulator bit-decision stage: slices the sign of the I or Q matched
// filter output at its strobe and emits an interleaved serial bit stream.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   di, dq    : signed I/Q filtered samples (DW bits, two's complement)
//   isync     : one-clock I decision strobe
//   qsync     : one-clock Q decision strobe
//   dout      : registered decided bit, holds between strobes
//   dout_vld  : one-clock qualifier for dout
//   lock      : strobe timing locked
//   sync_err  : one-clock pulse on a strobe protocol violation
// Build option:
//   MSK_DIFF_DEC_EN : when defined, dout = raw ^ previous raw bit
// ---------------------------------------------------------------------------
module msk_bit_decision
    import msk_demod_pkg::*;
#(
    parameter int DW       = 16,
    parameter int HALF_PER = SYNC_HALF_PER,
    parameter int TOL      = TOL_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] di,
    input  logic signed [DW-1:0] dq,
    input  logic                 isync,
    input  logic                 qsync,
    output logic                 dout,
    output logic                 dout_vld,
    output logic                 lock,
    output logic                 sync_err
);

    logic accept;
    logic raw;
    logic bit_d;
    logic dout_q, dout_d;
    logic vld_q, vld_d;

    // Only the sign bits carry decision information.
    logic unused_mag;
    assign unused_mag = ^{di[DW-2:0], dq[DW-2:0]};

    always_comb begin
        accept = isync ^ qsync;
        // Zero slices to 1: the decision is the inverted sign bit.
        raw    = isync ? ~di[DW-1] : ~dq[DW-1];
    end

`ifdef MSK_DIFF_DEC_EN
    logic prev_q;

    always_comb bit_d = raw ^ prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else if (accept) begin
            prev_q <= raw;
        end
    end
`else
    always_comb bit_d = raw;
`endif

    always_comb begin
        vld_d  = accept;
        dout_d = accept ? bit_d : dout_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            vld_q  <= vld_d;
        end
    end

    msk_sync_lock #(
        .HALF_PER (HALF_PER),
        .TOL      (TOL),
        .LOCK_CNT (LOCK_CNT)
    ) u_sync_lock (
        .clk        (clk),
        .rst        (rst),
        .isync_i    (isync),
        .qsync_i    (qsync),
        .lock_o     (lock),
        .sync_err_o (sync_err)
    );

    assign dout     = dout_q;
    assign dout_vld = vld_q;

endmodule

// File: tb/tb_msk_bit_decision.sv
module tb_msk_bit_decision;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] di = '0;
    logic signed [15:0] dq = '0;
    logic               isync = 1'b0;
    logic               qsync = 1'b0;
    logic               dout;
    logic               dout_vld;
    logic               lock;
    logic               sync_err;

    typedef struct packed {
        logic vld;
        logic dout;
        logic err;
        logic lock;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic tb_prev = 1'b0;
    logic last_dout = 1'b0;

    always #5 clk = ~clk;

    msk_bit_decision dut (
        .clk      (clk),
        .rst      (rst),
        .di       (di),
        .dq       (dq),
        .isync    (isync),
        .qsync    (qsync),
        .dout     (dout),
        .dout_vld (dout_vld),
        .lock     (lock),
        .sync_err (sync_err)
    );

    // Monitor: pops an expected record whenever the DUT reports something.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (!rst && (dout_vld || sync_err)) begin
            a = {dout_vld, dout, sync_err, lock};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got vld/dout/err/lock=%b, queue empty", a);
            end else begin
                e = q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL scoreboard: got vld/dout/err/lock=%b expected %b at %0t", a, e, $time);
                end
            end
        end
    end

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One clock of stimulus, starting and ending on a falling edge.
    task automatic cyc(input logic is, input logic qs,
                       input logic signed [15:0] vi, input logic signed [15:0] vq);
        isync = is; qsync = qs; di = vi; dq = vq;
        @(negedge clk);
        isync = 1'b0; qsync = 1'b0;
    endtask

    // Strobe `gap` clocks after the previous one; raw/err/lk are hand-computed.
    task automatic strobe(input int gap, input bit is_q, input logic signed [15:0] v,
                          input logic raw, input logic err, input logic lk);
        logic d;
        repeat (gap - 1) cyc(1'b0, 1'b0, 16'sd0, 16'sd0);
        d = raw;
`ifdef MSK_DIFF_DEC_EN
        d = raw ^ tb_prev;
        tb_prev = raw;
`endif
        last_dout = d;
        q.push_back({1'b1, d, err, lk});
        if (is_q) cyc(1'b0, 1'b1, 16'sd0, v);
        else      cyc(1'b1, 1'b0, v, 16'sd0);
    endtask

    // Illegal simultaneous strobes: no bit, dout holds, sync_err pulses.
    task automatic both(input int gap, input logic lk);
        repeat (gap - 1) cyc(1'b0, 1'b0, 16'sd0, 16'sd0);
        q.push_back({1'b0, last_dout, 1'b1, lk});
        cyc(1'b1, 1'b1, 16'sd5, 16'sd5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d expected 0", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [15:0] ev [9];
        logic               er [9];
        ev = '{16'sd1000, 16'sd1000, -16'sd1000, -16'sd1000, 16'sd1000,
               -16'sd1000, 16'sd1000, -16'sd1000, 16'sd1000};
        er = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state
        #23;
        check1("reset_dout", dout, 1'b0);
        check1("reset_vld", dout_vld, 1'b0);
        check1("reset_lock", lock, 1'b0);
        check1("reset_err", sync_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Nominal stream: 1,0,1,0..., lock after 9th strobe
        for (int k = 1; k <= 10; k++)
            strobe(16, (k % 2) == 0, (k % 2) ? 16'sd1000 : -16'sd1000,
                   (k % 2) == 1, 1'b0, k >= 9);

        // Jitter tolerance with zero/extreme samples
        strobe(14, 1'b0, 16'sd0,      1'b1, 1'b0, 1'b1);
        strobe(18, 1'b1, -16'sd32768, 1'b0, 1'b0, 1'b1);
        strobe(16, 1'b0, 16'sd32767,  1'b1, 1'b0, 1'b1);
        strobe(19, 1'b1, -16'sd1,     1'b0, 1'b0, 1'b0);

        // Relock after the out-of-window interval
        for (int k = 1; k <= 8; k++)
            strobe(16, (k % 2) == 0, (k % 2) ? 16'sd1000 : -16'sd1000,
                   (k % 2) == 1, 1'b0, k == 8);

        // Protocol violations
        strobe(16, 1'b0, 16'sd1000,  1'b1, 1'b0, 1'b1);
        strobe(16, 1'b0, 16'sd1000,  1'b1, 1'b1, 1'b0);
        strobe(16, 1'b1, -16'sd1000, 1'b0, 1'b0, 1'b0);
        both(16, 1'b0);
        strobe(1,  1'b0, 16'sd1000,  1'b1, 1'b0, 1'b0);

        // Climb back to lock; final Q sample positive so dout ends at 1
        for (int k = 1; k <= 7; k++)
            strobe(16, (k % 2) == 1,
                   (k == 7) ? 16'sd1000 : ((k % 2) ? -16'sd1000 : 16'sd1000),
                   (k == 7) ? 1'b1 : ((k % 2) == 0), 1'b0, k == 7);
        repeat (3) cyc(1'b0, 1'b0, 16'sd0, 16'sd0);
        check1("locked_before_rst", lock, 1'b1);

        // Asynchronous reset pulse mid-lock
        #2;
        rst = 1'b1;
        tb_prev = 1'b0;
        last_dout = 1'b0;
        #1;
        check1("async_rst_dout", dout, 1'b0);
        check1("async_rst_vld", dout_vld, 1'b0);
        check1("async_rst_lock", lock, 1'b0);
        check1("async_rst_err", sync_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Relock from scratch: raw 1,1,0,0,1,0,1,0,1
        for (int k = 0; k < 9; k++)
            strobe(16, (k % 2) == 1, ev[k], er[k], 1'b0, k == 8);

        repeat (4) cyc(1'b0, 1'b0, 16'sd0, 16'sd0);
        check1("dout_hold", dout, last_dout);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_records: got %0d left expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
